neuron: RTL and testbench



---
 rtl/neuron.sv | 140 ++++++++++++++
 tb/tb_neuron.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron.sv
// rtl/neuron.sv - integrate-and-fire neuron with 4-phase req/ack spike channels
module neuron #(
    parameter int weight    = 4,
    parameter int thold     = 8,
    parameter int data_bits = 4,
    parameter int delay_v [3] = '{1, 2, 3}
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    input  logic req_in,
    output logic ack_in,
    output logic data_out,
    output logic req_out,
    input  logic ack_out
);
    typedef enum logic [2:0] {IDLE, CAPTURE, INTEGRATE, EMIT, WAIT_ACK, RELEASE} state_t;

    // A zero stage latency still costs one cycle in its state.
    function automatic logic [15:0] eff_delay(input int d);
        return (d < 1) ? 16'd1 : 16'(d);
    endfunction

    localparam logic [15:0]        load_cap  = eff_delay(delay_v[0]);
    localparam logic [15:0]        load_int  = eff_delay(delay_v[1]);
    localparam logic [15:0]        load_emit = eff_delay(delay_v[2]);
    localparam logic [data_bits:0] weight_x  = (data_bits + 1)'(weight);
    localparam logic [data_bits:0] acc_max   = {1'b0, {data_bits{1'b1}}};

    state_t               state, state_n;
    logic [1:0]           req_sync, ack_sync;
    logic                 req_s, ack_s;
    logic [15:0]          cnt, cnt_n;
    logic                 token, token_n;
    logic                 fire, fire_n;
    logic [data_bits-1:0] acc, acc_n;
    logic                 ack_in_n, req_out_n, data_out_n;
    logic [data_bits:0]   sum;
    logic [data_bits-1:0] sum_sat;
    logic                 expired;

    assign req_s   = req_sync[1];
    assign ack_s   = ack_sync[1];
    assign expired = (cnt <= 16'd1);
    assign sum     = {1'b0, acc} + (token ? weight_x : '0);
    assign sum_sat = (sum > acc_max) ? acc_max[data_bits-1:0] : sum[data_bits-1:0];

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        token_n    = token;
        fire_n     = fire;
        acc_n      = acc;
        ack_in_n   = ack_in;
        req_out_n  = req_out;
        data_out_n = data_out;
        case (state)
            IDLE: begin
                if (req_s) begin
                    token_n = data_in;
                    cnt_n   = load_cap;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (expired) begin
                    ack_in_n = 1'b1;
                    cnt_n    = load_int;
                    state_n  = INTEGRATE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            INTEGRATE: begin
                if (expired) begin
                    if (32'(sum_sat) >= 32'(thold)) begin
                        fire_n = 1'b1;
                        acc_n  = '0;
                    end else begin
                        fire_n = 1'b0;
                        acc_n  = sum_sat;
                    end
                    cnt_n   = load_emit;
                    state_n = EMIT;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            EMIT: begin
                if (expired) begin
                    data_out_n = fire;
                    req_out_n  = 1'b1;
                    state_n    = WAIT_ACK;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    req_out_n = 1'b0;
                    state_n   = RELEASE;
                end
            end
            RELEASE: begin
                // Both channels must be back to zero before a new token is accepted.
                if (!ack_s && !req_s) begin
                    ack_in_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_sync <= '0;
            ack_sync <= '0;
            cnt      <= '0;
            token    <= 1'b0;
            fire     <= 1'b0;
            acc      <= '0;
            ack_in   <= 1'b0;
            req_out  <= 1'b0;
            data_out <= 1'b0;
        end else begin
            state    <= state_n;
            req_sync <= {req_sync[0], req_in};
            ack_sync <= {ack_sync[0], ack_out};
            cnt      <= cnt_n;
            token    <= token_n;
            fire     <= fire_n;
            acc      <= acc_n;
            ack_in   <= ack_in_n;
            req_out  <= req_out_n;
            data_out <= data_out_n;
        end
    end
endmodule

// File: tb/tb_neuron.sv
// tb/tb_neuron.sv - randomized self-checking bench for neuron against an arithmetic model
module tb_neuron;
    logic clk = 1'b0;
    logic rst;
    logic data_in [2];
    logic req_in  [2];
    logic ack_in  [2];
    logic data_out[2];
    logic req_out [2];
    logic ack_out [2];

    int errors = 0;
    int checks = 0;

    // Instance 0 uses defaults; instance 1 has an unreachable threshold.
    int acc_m   [2] = '{0, 0};
    int thold_m [2] = '{8, 20};
    localparam int weight_m = 4;
    localparam int acc_cap  = 15;
    localparam int lat_ack  = 4;
    localparam int lat_req  = 9;

    always #5 clk = ~clk;

    neuron u0 (
        .clk(clk), .rst(rst), .data_in(data_in[0]), .req_in(req_in[0]), .ack_in(ack_in[0]),
        .data_out(data_out[0]), .req_out(req_out[0]), .ack_out(ack_out[0])
    );

    neuron #(.weight(4), .thold(20), .data_bits(4)) u1 (
        .clk(clk), .rst(rst), .data_in(data_in[1]), .req_in(req_in[1]), .ack_in(ack_in[1]),
        .data_out(data_out[1]), .req_out(req_out[1]), .ack_out(ack_out[1])
    );

    function automatic int get_acc(input int idx);
        return (idx == 1) ? int'(u1.acc) : int'(u0.acc);
    endfunction

    function automatic logic model_step(input int idx, input logic tok);
        int a;
        a = acc_m[idx] + (tok ? weight_m : 0);
        if (a > acc_cap) a = acc_cap;
        if (a >= thold_m[idx]) begin
            acc_m[idx] = 0;
            return 1'b1;
        end
        acc_m[idx] = a;
        return 1'b0;
    endfunction

    task automatic run_token(input int idx, input logic tok, input bit ack_early, input bit drop_early,
                             output logic got, output logic held, output int ack_lat,
                             output int lat, output int hi, output bit ok);
        int n;
        ok = 1; ack_lat = -1; hi = 0;
        data_in[idx] = tok;
        if (ack_early) ack_out[idx] = 1'b1;
        req_in[idx] = 1'b1;
        n = 0;
        while (req_out[idx] !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
            if (ack_in[idx] === 1'b1 && ack_lat < 0) ack_lat = n;
            if (drop_early && n == 3) req_in[idx] = 1'b0;
        end
        if (n >= 200) ok = 0;
        lat = n;
        got = data_out[idx];
        ack_out[idx] = 1'b1;
        n = 0;
        while (req_out[idx] === 1'b1 && n < 50) begin @(negedge clk); n++; hi++; end
        if (n >= 50) ok = 0;
        req_in[idx]  = 1'b0;
        ack_out[idx] = 1'b0;
        n = 0;
        while (ack_in[idx] === 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) ok = 0;
        held = data_out[idx];
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ack_in[i] !== 1'b0 || req_out[i] !== 1'b0 || data_out[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: ack_in=%b req_out=%b data_out=%b, required all 0",
                         i, ack_in[i], req_out[i], data_out[i]);
            end
            checks++;
            if (get_acc(i) !== 0) begin
                errors++;
                $display("FAIL reset_acc inst%0d: got %0d, required 0", i, get_acc(i));
            end
        end
    endtask

    task automatic test_basic();
        logic got, held, exp;
        int ack_lat, lat, hi;
        bit ok;
        logic toks [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            run_token(0, toks[k], 1'b0, 1'b0, got, held, ack_lat, lat, hi, ok);
            exp = model_step(0, toks[k]);
            checks++;
            if (!ok) begin errors++; $display("FAIL basic_timeout tok%0d: handshake stalled, required completion", k); end
            checks++;
            if (got !== exp || held !== exp) begin
                errors++;
                $display("FAIL basic_data tok%0d: data_out=%b held=%b, required %b", k, got, held, exp);
            end
            checks++;
            if (get_acc(0) !== acc_m[0]) begin
                errors++;
                $display("FAIL basic_acc tok%0d: got %0d, required %0d", k, get_acc(0), acc_m[0]);
            end
            checks++;
            if (ack_lat !== lat_ack || lat !== lat_req) begin
                errors++;
                $display("FAIL basic_latency tok%0d: ack_in after %0d req_out after %0d, required %0d and %0d",
                         k, ack_lat, lat, lat_ack, lat_req);
            end
        end
    endtask

    task automatic test_saturation();
        logic got, held, exp;
        int ack_lat, lat, hi;
        bit ok;
        for (int k = 0; k < 5; k++) begin
            run_token(1, 1'b1, 1'b0, 1'b0, got, held, ack_lat, lat, hi, ok);
            exp = model_step(1, 1'b1);
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL sat_data tok%0d: ok=%0d data_out=%b, required ok=1 data_out=%b", k, ok, got, exp);
            end
            checks++;
            if (get_acc(1) !== acc_m[1]) begin
                errors++;
                $display("FAIL sat_acc tok%0d: got %0d, required %0d", k, get_acc(1), acc_m[1]);
            end
        end
    endtask

    task automatic test_ack_early();
        logic got, held, exp;
        int ack_lat, lat, hi;
        bit ok;
        run_token(0, 1'b1, 1'b1, 1'b0, got, held, ack_lat, lat, hi, ok);
        exp = model_step(0, 1'b1);
        checks++;
        if (!ok || hi !== 1) begin
            errors++;
            $display("FAIL ack_early_pulse: ok=%0d req_out high %0d cycles, required ok=1 and 1 cycle", ok, hi);
        end
        checks++;
        if (got !== exp || get_acc(0) !== acc_m[0]) begin
            errors++;
            $display("FAIL ack_early_data: data_out=%b acc=%0d, required %b acc=%0d", got, get_acc(0), exp, acc_m[0]);
        end
    endtask

    task automatic test_random();
        logic got, held, exp, tok;
        int ack_lat, lat, hi;
        bit ok, ae, de;
        for (int k = 0; k < 16; k++) begin
            tok = 1'($urandom_range(0, 1));
            ae  = 1'($urandom_range(0, 1));
            de  = 1'($urandom_range(0, 1));
            run_token(0, tok, ae, de, got, held, ack_lat, lat, hi, ok);
            exp = model_step(0, tok);
            checks++;
            if (!ok || got !== exp || held !== exp || lat !== lat_req) begin
                errors++;
                $display("FAIL rand_token%0d (tok=%b early_ack=%0d early_drop=%0d): ok=%0d data=%b held=%b lat=%0d, required ok=1 data=%b lat=%0d",
                         k, tok, ae, de, ok, got, held, lat, exp, lat_req);
            end
            checks++;
            if (get_acc(0) !== acc_m[0]) begin
                errors++;
                $display("FAIL rand_acc%0d: got %0d, required %0d", k, get_acc(0), acc_m[0]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic got, held, exp;
        int ack_lat, lat, hi;
        bit ok;
        data_in[0] = 1'b1;
        req_in[0]  = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (ack_in[0] !== 1'b1) begin
            errors++;
            $display("FAIL midflight_pre: ack_in=%b, required 1 during integrate", ack_in[0]);
        end
        rst = 1'b0;
        #1;
        acc_m[0] = 0;
        acc_m[1] = 0;
        test_reset();
        req_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_token(0, 1'b1, 1'b0, 1'b0, got, held, ack_lat, lat, hi, ok);
        exp = model_step(0, 1'b1);
        checks++;
        if (!ok || got !== exp || get_acc(0) !== acc_m[0] || ack_lat !== lat_ack || lat !== lat_req) begin
            errors++;
            $display("FAIL midflight_recover: ok=%0d data=%b acc=%0d ack_lat=%0d lat=%0d, required ok=1 data=%b acc=%0d ack_lat=%0d lat=%0d",
                     ok, got, get_acc(0), ack_lat, lat, exp, acc_m[0], lat_ack, lat_req);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_in[i] = 1'b0; req_in[i] = 1'b0; ack_out[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_basic();
        test_saturation();
        test_ack_early();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
